// File: rtl/dff_reg_arbiter_pkg.sv
// dff_arb_pkg: shared types, counter width and round-robin pick for dff_reg_arbiter
package dff_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
  localparam int CNT_W = 16;
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [2:0] w;
    int k;
    w = ptr;
    for (int i = 7; i >= 0; i--) begin
      k = (int'(ptr) + i) % n;
      if (i < n && req[3'(k)]) w = 3'(k);
    end
    return w;
  endfunction
endpackage

// File: rtl/dff_reg_arbiter_if.sv
// dff_reg_arbiter_if: requester/arbiter bundle; grant_cnt present only with DFF_ARB_STATS_EN
interface dff_reg_arbiter_if
  import dff_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0] req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] ack;
  logic [WIDTH-1:0] q;
  logic [$clog2(N_REQ)-1:0] owner;
  logic busy;
`ifdef DFF_ARB_STATS_EN
  logic [N_REQ*CNT_W-1:0] grant_cnt;
  modport master(output req, wdata, input gnt, ack, q, owner, busy, grant_cnt);
  modport slave(input req, wdata, output gnt, ack, q, owner, busy, grant_cnt);
`else
  modport master(output req, wdata, input gnt, ack, q, owner, busy);
  modport slave(input req, wdata, output gnt, ack, q, owner, busy);
`endif
endinterface

// File: rtl/dff_reg_arbiter_dff_reg.sv
// dff_reg: WIDTH-bit D register with load enable and synchronous active-high reset
module dff_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) q <= rst ? '0 : en ? d : q;
endmodule

// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: round-robin write arbiter for one shared register (optional DFF_ARB_STATS_EN grant counters)
module dff_reg_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  dff_reg_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  state_t r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_win;
  logic [IW-1:0] r_owner;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_ack;
  logic [7:0] w_req;
  logic [2:0] w_pick;
  logic w_load;
  logic [WIDTH-1:0] w_d;
  assign w_req = 8'(bus.req);
  assign w_pick = rr_pick(w_req, 3'(r_ptr), N_REQ);
  assign w_load = r_state == GRANT;
  assign w_d = bus.wdata[r_win*WIDTH +: WIDTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_win <= '0;
      r_owner <= '0;
      r_gnt <= '0;
      r_ack <= '0;
    end else begin
      case (r_state)
        IDLE: if (|bus.req) begin
          r_win <= IW'(w_pick);
          r_gnt <= N_REQ'(1) << w_pick;
          r_state <= GRANT;
        end
        GRANT: begin
          r_gnt <= '0;
          r_ack <= N_REQ'(1) << r_win;
          r_owner <= r_win;
          r_state <= ACK;
        end
        ACK: begin
          r_ack <= '0;
          r_ptr <= (32'(r_win) == N_REQ - 1) ? '0 : r_win + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  dff_reg #(.WIDTH(WIDTH)) u_reg (
    .clk(clk),
    .rst(rst),
    .en(w_load),
    .d(w_d),
    .q(bus.q)
  );
  assign bus.gnt = r_gnt;
  assign bus.ack = r_ack;
  assign bus.owner = r_owner;
  assign bus.busy = r_state != IDLE;
`ifdef DFF_ARB_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) r_cnt <= rst ? '0 : (r_ack[i] && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    assign bus.grant_cnt[i*CNT_W +: CNT_W] = r_cnt;
  end
`endif
endmodule

// File: tb/tb_dff_reg_arbiter.sv
// tb_dff_reg_arbiter: directed plus random stimulus checked against a transaction timeline model
module tb_dff_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dff_reg_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus();
  dff_reg_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int t_sel = -100;
  int win = 0;
  int ptr = 0;
  logic [W-1:0] m_q = '0;
  int m_owner = 0;
  int cnt [N];
  int gq [$];
  int tq [$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction
  task automatic tick();
    int d;
    d = cyc - t_sel;
    if (rst) begin
      t_sel = -100;
      ptr = 0;
      m_q = '0;
      m_owner = 0;
      for (int i = 0; i < N; i++) cnt[i] = 0;
    end else if (d >= 3 && bus.req != 0) begin
      win = pick(bus.req);
      t_sel = cyc;
    end else if (d == 1) begin
      m_q = bus.wdata[win*W +: W];
      m_owner = win;
    end else if (d == 2) begin
      ptr = (win + 1) % N;
      if (cnt[win] < 65535) cnt[win]++;
    end
    @(posedge clk);
    cyc++;
    #1;
    d = cyc - t_sel;
    chk("gnt", 64'(bus.gnt), d == 1 ? 64'(1) << win : 64'(0));
    chk("ack", 64'(bus.ack), d == 2 ? 64'(1) << win : 64'(0));
    chk("busy", 64'(bus.busy), 64'(d < 3));
    chk("q", 64'(bus.q), 64'(m_q));
    chk("owner", 64'(bus.owner), 64'(m_owner));
`ifdef DFF_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("grant_cnt", 64'(bus.grant_cnt[i*16 +: 16]), 64'(cnt[i]));
`endif
    for (int i = 0; i < N; i++) if (bus.gnt[i]) begin
      gq.push_back(i);
      tq.push_back(cyc);
    end
    @(negedge clk);
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  task automatic set_wd(input int i, input logic [W-1:0] v);
    bus.wdata[i*W +: W] = v;
  endtask
  initial begin
    bus.req = '0;
    bus.wdata = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    @(negedge clk);
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(3);
    set_wd(2, 8'hA5);
    bus.req = 4'b0100;
    tick();
    chk("single_gnt", 64'(bus.gnt), 64'h4);
    tick();
    chk("single_ack", 64'(bus.ack), 64'h4);
    chk("single_q", 64'(bus.q), 64'hA5);
    chk("single_owner", 64'(bus.owner), 64'd2);
    bus.req = '0;
    run(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_wd(i, W'(8'h10 + i));
    gq.delete();
    tq.delete();
    bus.req = 4'b1111;
    run(13);
    bus.req = '0;
    run(3);
    chk("rr_count", 64'(gq.size()), 64'd5);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk("rr_order", 64'(gq[i]), 64'(i % N));
    for (int i = 1; i < 5 && i < tq.size(); i++) chk("rr_spacing", 64'(tq[i] - tq[i-1]), 64'd3);
    set_wd(1, 8'h5A);
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    tick();
    chk("drop_ack", 64'(bus.ack), 64'h2);
    chk("drop_q", 64'(bus.q), 64'h5A);
    run(2);
    set_wd(0, 8'h3C);
    bus.req = 4'b0001;
    run(3);
    bus.req = '0;
    run(1);
    chk("pre_rst_q", 64'(bus.q), 64'h3C);
    set_wd(0, 8'hFF);
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_q", 64'(bus.q), 64'h0);
    chk("rst_mid_ack", 64'(bus.ack), 64'h0);
    tick();
    chk("rst_mid_idle", 64'(bus.busy), 64'h0);
    set_wd(3, 8'h77);
    bus.req = 4'b1000;
    run(15);
    bus.req = '0;
    run(3);
`ifdef DFF_ARB_STATS_EN
    chk("stats_req3", 64'(bus.grant_cnt[3*16 +: 16]), 64'd5);
    chk("stats_req0", 64'(bus.grant_cnt[15:0]), 64'd0);
`endif
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        bit fl;
        fl = (cyc - t_sel < 3) && (win == i);
        if (bus.req[i]) begin
          if (!fl && $urandom_range(7) == 0) bus.req[i] = 1'b0;
        end else if (!fl && $urandom_range(2) == 0) begin
          set_wd(i, W'($urandom));
          bus.req[i] = 1'b1;
        end
      end
      rst = ($urandom_range(63) == 0);
      tick();
    end
    rst = 1'b0;
    bus.req = '0;
    run(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
